// File: rtl/secp256k1_pkg.sv
// Shared definitions for the secp256k1 arithmetic blocks: field width, prime,
// and the multiplier-arbiter state encoding.
package secp256k1_pkg;

  localparam int FIELD_W = 256;

  localparam logic [FIELD_W-1:0] SECP256K1_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    RESP  = ST_RESP
  } arb_state_t;

  // Index width for an n-entry vector, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/secp256k1_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N; returns one-hot grant, its index, and an any-hit flag.
module secp256k1_rr_pick
  import secp256k1_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

  logic [IDX_W-1:0] cand [N];
  logic [N-1:0]     hit;

  // cand[gi] is the requester visited gi steps after ptr.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum       = {1'b0, ptr} + (IDX_W + 1)'(gi);
      assign cand[gi]  = (sum >= N_W) ? IDX_W'(sum - N_W) : IDX_W'(sum);
      assign hit[gi]   = req[cand[gi]];
    end
  endgenerate

  always_comb begin
    idx   = '0;
    any   = 1'b0;
    grant = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (hit[k]) begin
        idx = cand[k];
        any = 1'b1;
      end
    end
    if (any) grant = N'(1) << idx;
  end

endmodule

// File: rtl/secp256k1_mul_arbiter.sv
// Round-robin sharing of one secp256k1_mul_mod between N_REQ requesters.
// Define SECP256K1_MULARB_PERF_EN to add op_count / stall_count ports.
module secp256k1_mul_arbiter
  import secp256k1_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [FIELD_W*N_REQ-1:0]   req_a,
  input  logic [FIELD_W*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]           rsp_valid,
  input  logic [N_REQ-1:0]           rsp_ready,
  output logic [FIELD_W-1:0]         rsp_result,
  output logic                       busy,
`ifdef SECP256K1_MULARB_PERF_EN
  output logic [31:0]                op_count,
  output logic [31:0]                stall_count,
`endif
  output logic                       mul_start,
  output logic [FIELD_W-1:0]         mul_a,
  output logic [FIELD_W-1:0]         mul_b,
  input  logic [FIELD_W-1:0]         mul_result,
  input  logic                       mul_done
);

  arb_state_t state_reg, state_next;

  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [IDX_W-1:0]   grant_idx_reg;
  logic [FIELD_W-1:0] mul_a_reg, mul_b_reg, result_reg;

  logic [N_REQ-1:0]   pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               rsp_fire;

  logic [FIELD_W-1:0] a_slice [N_REQ];
  logic [FIELD_W-1:0] b_slice [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign a_slice[gi] = req_a[FIELD_W*gi +: FIELD_W];
      assign b_slice[gi] = req_b[FIELD_W*gi +: FIELD_W];
    end
  endgenerate

  secp256k1_rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_reg),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign rsp_fire = (state_reg == RESP) && rsp_ready[grant_idx_reg];

  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    rsp_valid  = '0;
    mul_start  = 1'b0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        // Gated by rst_n so a requester held valid through reset sees no accept.
        if (rst_n) req_ready = pick_grant;
        if (pick_any) state_next = ISSUE;
      end
      ISSUE: begin
        mul_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (mul_done) state_next = RESP;
      end
      RESP: begin
        rsp_valid = N_REQ'(1) << grant_idx_reg;
        if (rsp_fire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      grant_idx_reg <= '0;
      mul_a_reg     <= '0;
      mul_b_reg     <= '0;
      result_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && pick_any) begin
        grant_idx_reg <= pick_idx;
        mul_a_reg     <= a_slice[pick_idx];
        mul_b_reg     <= b_slice[pick_idx];
      end
      if (state_reg == WAIT && mul_done) result_reg <= mul_result;
      if (rsp_fire) begin
        rr_ptr_reg <= (grant_idx_reg == IDX_W'(N_REQ - 1)) ? '0 : grant_idx_reg + 1'b1;
      end
    end
  end

  assign mul_a      = mul_a_reg;
  assign mul_b      = mul_b_reg;
  assign rsp_result = result_reg;

`ifdef SECP256K1_MULARB_PERF_EN
  logic [31:0] op_count_reg, stall_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_reg    <= '0;
      stall_count_reg <= '0;
    end else begin
      if (rsp_fire) op_count_reg <= op_count_reg + 32'd1;
      if (state_reg == RESP && !rsp_ready[grant_idx_reg]) stall_count_reg <= stall_count_reg + 32'd1;
    end
  end

  assign op_count    = op_count_reg;
  assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_secp256k1_mul_arbiter.sv
// Self-checking bench for secp256k1_mul_arbiter with a behavioural multiplier
// and a transaction-level model; honours SECP256K1_MULARB_PERF_EN when defined.
module tb_secp256k1_mul_arbiter;
  import secp256k1_pkg::*;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [256*N-1:0] req_a = '0;
  logic [256*N-1:0] req_b = '0;
  logic [N-1:0]     rsp_valid;
  logic [N-1:0]     rsp_ready = '1;
  logic [255:0]     rsp_result;
  logic             busy;
  logic             mul_start;
  logic [255:0]     mul_a, mul_b;
  logic [255:0]     mul_result = '0;
  logic             mul_done = 1'b0;
`ifdef SECP256K1_MULARB_PERF_EN
  logic [31:0]      op_count, stall_count;
`endif

  int tests = 0;
  int fails = 0;
  int mul_lat = 2;
  int start_cnt = 0;

  secp256k1_mul_arbiter #(.N_REQ(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .busy        (busy),
`ifdef SECP256K1_MULARB_PERF_EN
    .op_count    (op_count),
    .stall_count (stall_count),
`endif
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_result  (mul_result),
    .mul_done    (mul_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] mod_mul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] prod;
    logic [511:0] p_wide;
    logic [511:0] r;
    prod   = {256'd0, a} * {256'd0, b};
    p_wide = {256'd0, SECP256K1_P};
    r      = prod % p_wide;
    return r[255:0];
  endfunction

  // Expected grant: first valid requester scanning from ptr upward, wrapping.
  function automatic logic [N-1:0] rr_expect(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (v[j]) return N'(1) << j;
    end
    return '0;
  endfunction

  function automatic int oh_index(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  // Behavioural multiplier: result after mul_lat cycles, aborted by reset.
  initial begin
    logic [255:0] ma, mb;
    bit aborted;
    forever begin
      @(negedge clk);
      if (rst_n && mul_start) begin
        ma = mul_a;
        mb = mul_b;
        aborted = 1'b0;
        for (int k = 0; k < mul_lat; k++) begin
          @(posedge clk);
          #1;
          if (!rst_n) aborted = 1'b1;
        end
        if (!aborted) begin
          mul_result = mod_mul(ma, mb);
          mul_done   = 1'b1;
          @(posedge clk);
          #1;
          mul_done   = 1'b0;
          mul_result = {8{32'hDEADBEEF}};
        end
      end
    end
  end

  // Transaction-level model and per-cycle comparison.
  int           mdl_ptr = 0;
  bit           outstanding = 1'b0;
  bit           start_due = 1'b0;
  int           exp_idx = 0;
  logic [255:0] exp_a = '0, exp_b = '0, exp_res = '0;
  int           mdl_ops = 0, mdl_stalls = 0;

  initial begin
    logic [N-1:0] exp_ready;
    bit was_out;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mdl_ptr = 0;
        outstanding = 1'b0;
        start_due = 1'b0;
        chk("rst_ctrl", {req_ready, rsp_valid, busy, mul_start}, '0);
        chk("rst_mul_a", mul_a, '0);
        chk("rst_rsp_result", rsp_result, '0);
      end else begin
        was_out   = outstanding;
        exp_ready = was_out ? '0 : rr_expect(req_valid, mdl_ptr);
        chk("req_ready", req_ready, exp_ready);
        chk("busy", busy, was_out);
        chk("mul_start", mul_start, start_due);
        if (mul_start) start_cnt++;
        start_due = 1'b0;
        if (was_out) begin
          chk("mul_a_hold", mul_a, exp_a);
          chk("mul_b_hold", mul_b, exp_b);
          if (rsp_valid != '0) begin
            chk("rsp_valid_idx", rsp_valid, N'(1) << exp_idx);
            chk("rsp_result", rsp_result, exp_res);
            if (rsp_ready[exp_idx]) begin
              outstanding = 1'b0;
              mdl_ptr = (exp_idx + 1) % N;
              mdl_ops++;
            end else begin
              mdl_stalls++;
            end
          end
        end else begin
          chk("rsp_valid_idle", rsp_valid, '0);
          if (exp_ready != '0) begin
            exp_idx     = oh_index(exp_ready);
            exp_a       = req_a[256*exp_idx +: 256];
            exp_b       = req_b[256*exp_idx +: 256];
            exp_res     = mod_mul(exp_a, exp_b);
            outstanding = 1'b1;
            start_due   = 1'b1;
            $display("[TB] grant %0d a=%0h b=%0h", exp_idx, exp_a, exp_b);
          end
        end
      end
    end
  end

  task automatic wait_accept(input int idx, input string nm);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (req_ready[idx]) seen = 1'b1;
    end
    chk(nm, seen, 1'b1);
  endtask

  task automatic wait_rsp(input int idx, input string nm);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid[idx]) seen = 1'b1;
    end
    chk(nm, seen, 1'b1);
  endtask

  task automatic run_op(input int idx, input logic [255:0] a, input logic [255:0] b,
                        input int stall, input int lat, input logic [255:0] exp, input string nm);
    mul_lat = lat;
    if (stall > 0) rsp_ready[idx] = 1'b0;
    req_a[256*idx +: 256] = a;
    req_b[256*idx +: 256] = b;
    req_valid[idx] = 1'b1;
    wait_accept(idx, {nm, "_accept"});
    @(posedge clk);
    #1;
    req_valid[idx] = 1'b0;
    wait_rsp(idx, {nm, "_rsp"});
    chk(nm, rsp_result, exp);
    $display("[TB] op %s req=%0d result=%0h", nm, idx, rsp_result);
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1;
      rsp_ready[idx] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [255:0] pm1, two255;
    int s0;
    int order[$];
    int exp_order[5];
    bit done_flag;

    pm1 = SECP256K1_P - 256'd1;
    two255 = 256'd1 << 255;
    exp_order = '{0, 1, 2, 3, 0};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Small product, single start pulse, busy drops after the handshake.
    s0 = start_cnt;
    run_op(0, 256'd2, 256'd3, 0, 3, 256'd6, "t1_mul");
    chk("t1_start_once", 256'(start_cnt - s0), 256'd1);
    chk("t1_busy_low", busy, 1'b0);

    // Field-boundary operands.
    run_op(2, pm1, pm1, 0, 5, 256'd1, "t2_pm1_sq");
    run_op(1, two255, 256'd2, 0, 1, 256'h1000003D1, "t2_wrap");

    // All requesters held valid from rr_ptr = 0.
    pulse_reset();
    @(posedge clk);
    #1;
    mul_lat = 2;
    for (int i = 0; i < N; i++) begin
      req_a[256*i +: 256] = 256'(i + 2);
      req_b[256*i +: 256] = 256'(i + 11);
    end
    req_valid = '1;
    for (int n = 0; n < 5; n++) begin
      done_flag = 1'b0;
      for (int c = 0; c < 300 && !done_flag; c++) begin
        @(negedge clk);
        if (req_ready != '0) done_flag = 1'b1;
      end
      chk("t3_accept", done_flag, 1'b1);
      order.push_back(oh_index(req_ready));
      @(posedge clk);
      #1;
      req_a[256*order[n] +: 256] = 256'(100 + n);
      req_b[256*order[n] +: 256] = 256'(200 + order[n]);
      if (n == 4) req_valid = '0;
    end
    done_flag = 1'b0;
    for (int c = 0; c < 300 && !done_flag; c++) begin
      @(negedge clk);
      if (!busy) done_flag = 1'b1;
    end
    chk("t3_drain", done_flag, 1'b1);
    for (int k = 0; k < 5; k++) chk("t3_order", 256'(order[k]), 256'(exp_order[k]));

    // Response stall with another requester waiting.
    @(posedge clk);
    #1;
    mul_lat = 4;
    rsp_ready[1] = 1'b0;
    req_a[256*1 +: 256] = 256'h1234;
    req_b[256*1 +: 256] = 256'h10;
    req_valid[1] = 1'b1;
    wait_accept(1, "t4_accept");
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    req_a[256*3 +: 256] = 256'd9;
    req_b[256*3 +: 256] = 256'd9;
    req_valid[3] = 1'b1;
    wait_rsp(1, "t4_rsp");
    for (int k = 0; k < 10; k++) begin
      chk("t4_stall_valid", rsp_valid, 4'b0010);
      chk("t4_stall_result", rsp_result, 256'h12340);
      chk("t4_stall_ready", req_ready, '0);
      chk("t4_stall_start", mul_start, 1'b0);
      if (k < 9) @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready[1] = 1'b1;
    wait_accept(3, "t4_next_accept");
    @(posedge clk);
    #1;
    req_valid[3] = 1'b0;
    wait_rsp(3, "t4_next_rsp");
    chk("t4_next_result", rsp_result, 256'd81);
    @(posedge clk);
    #1;

    // Reset during WAIT abandons the op.
    mul_lat = 20;
    req_a[256*1 +: 256] = 256'd3;
    req_b[256*1 +: 256] = 256'd4;
    req_valid[1] = 1'b1;
    wait_accept(1, "t5_accept");
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_async_ctrl", {req_ready, rsp_valid, busy, mul_start}, '0);
    chk("t5_async_mul_a", mul_a, '0);
    chk("t5_async_mul_b", mul_b, '0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(2, 256'd5, 256'd7, 0, 3, 256'd35, "t5_after_reset");

`ifdef SECP256K1_MULARB_PERF_EN
    pulse_reset();
    @(posedge clk);
    #1;
    chk("t6_op_reset", op_count, 32'd0);
    run_op(0, 256'd2, 256'd2, 0, 2, 256'd4, "t6_op0");
    run_op(1, 256'd3, 256'd3, 1, 3, 256'd9, "t6_op1");
    run_op(2, 256'd4, 256'd4, 3, 1, 256'd16, "t6_op2");
    chk("t6_op_count", op_count, 32'd3);
    chk("t6_stall_count", stall_count, 32'd4);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/secp256k1_mul_arbiter.md
Name: secp256k1_mul_arbiter

Overview:
Shares one secp256k1_mul_mod instance between N_REQ requesters, e.g. point-add and point-double sequencers.
- Round-robin arbitration; one multiplication in flight at a time.
- Valid/ready handshake on the request and response side of each requester.
- Drives the multiplier start/a/b, waits for its done pulse, returns the product to the winning requester only.

Parameters:
N_REQ, 4, number of requesters (1..16)
IDX_W, $clog2(N_REQ) (min 1), localparam, grant index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept; one-hot or zero
req_a  in  256*N_REQ  operand a; slice i = [256*i+255:256*i]
req_b  in  256*N_REQ  operand b, same packing
rsp_valid  out  N_REQ  per-requester response valid; one-hot or zero
rsp_ready  in  N_REQ  per-requester response accept
rsp_result  out  256  (a*b) mod p, meaningful where rsp_valid set
busy  out  1  high in every state except IDLE
mul_start  out  1  to multiplier start
mul_a  out  256  to multiplier a
mul_b  out  256  to multiplier b
mul_result  in  256  from multiplier result
mul_done  in  1  from multiplier done (1-cycle pulse)

Behaviour:
- Reset, async: all outputs 0, state IDLE, rr_ptr 0, operand/result registers 0. Reset mid-operation abandons the op with no response. The multiplier shares rst_n.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, grant g = first set bit scanning rr_ptr, rr_ptr+1, ... wrapping mod N_REQ.
  - Same cycle: req_ready[g]=1 combinationally. Handshake completes on req_valid[g]&req_ready[g].
  - At the edge: latch req_a/req_b slice g into mul_a/mul_b and g into grant_idx; go to ISSUE.
  - No req_valid: stay in IDLE.
- ISSUE: mul_start=1 for exactly one cycle; go to WAIT.
- WAIT:
  - mul_start=0; mul_a/mul_b held stable for the whole operation.
  - On mul_done=1: latch mul_result into rsp_result; go to RESP.
  - No timeout; the multiplier latency is not hard-coded.
- RESP:
  - rsp_valid[grant_idx]=1, rsp_result stable until rsp_ready[grant_idx].
  - On handshake: rsp_valid clears, rr_ptr <= (grant_idx+1) mod N_REQ, go to IDLE.
  - rsp_ready of other requesters is ignored.
- req_ready is 0 outside IDLE. Requesters hold valid and operands until accepted; valid deasserted before acceptance is legal and simply not granted.
- Throughput: one op per (multiplier latency + 3 + response stall) cycles. IDLE does not arbitrate in the same cycle RESP completes.
- mul_done outside WAIT is ignored.
- N_REQ=1: rr_ptr stays 0.
- Fairness: a continuously requesting agent waits at most N_REQ-1 ops.

Optional Feature:
SECP256K1_MULARB_PERF_EN
- Defined: adds output ports op_count[31:0] and stall_count[31:0], both reset to 0.
  - op_count increments on each response handshake and wraps.
  - stall_count increments on each RESP cycle with rsp_ready[grant_idx]=0 and wraps.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package secp256k1_pkg: SECP256K1_P constant, FIELD_W=256, state encoding localparams.
- One sub-module, secp256k1_rr_pick: combinational round-robin priority picker (req vector, rr_ptr -> one-hot grant + index), reusable by other arbiters in the design.

Test Plan:
1. Req0 a=2, b=3, rsp_ready tied 1 -> rsp_valid[0] with rsp_result=6; mul_start pulses exactly once; busy falls after the handshake.
2. Req2 a=b=p-1 -> rsp_result=1. Req1 a=2^255, b=2 -> rsp_result=0x1000003D1.
3. All four req_valid held high, distinct operands, rr_ptr=0 -> grant order 0,1,2,3,0; each rsp_valid one-hot to the correct index with the correct product.
4. rsp_ready[g] held 0 for 10 cycles in RESP -> rsp_result/rsp_valid stable, no req_ready asserted, mul_start stays 0; release -> next grant proceeds.
5. rst_n low during WAIT -> all outputs 0 asynchronously; after release, request a=5, b=7 -> result 35 to the correct requester; no stale response.
6. PERF_EN defined: 3 ops with 4 total stall cycles -> op_count=3, stall_count=4; build with the macro undefined also compiles and passes 1-5.
